// File: rtl/debounce3_if.sv
// Signal bundle between the raw-input source and the debounce3 conditioner.
// The master drives the raw inputs; the slave (debounce3) drives the conditioned outputs.
interface debounce3_if;
    logic a_raw;
    logic b_raw;
    logic c_raw;
    logic a;
    logic b;
    logic c;
    logic settled;
    logic changed;

    modport master (
        output a_raw, b_raw, c_raw,
        input  a, b, c, settled, changed
    );

    modport slave (
        input  a_raw, b_raw, c_raw,
        output a, b, c, settled, changed
    );
endinterface

// File: rtl/debounce3.sv
// Three-channel conditioner: 2-flop synchronizer plus stability-count debounce per
// channel. It produces the and3 operands, a settled flag and a toggle strobe.
module debounce3 #(
    parameter int STABLE_CYCLES = 4
) (
    input logic       clk,
    input logic       rst_n,
    debounce3_if.slave io
);
    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // Bit 2 = channel A, bit 1 = channel B, bit 0 = channel C.
    logic [2:0]       raw;
    logic [2:0]       s1_q, s1_d;
    logic [2:0]       s2_q, s2_d;
    logic [2:0]       q_q, q_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic             changed_q, changed_d;

    assign raw = {io.a_raw, io.b_raw, io.c_raw};

    always_comb begin
        s1_d = raw;
        s2_d = s1_q;
        q_d  = q_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            // Any agreement wipes the count, so only an unbroken run of mismatches can toggle.
            if (s2_q[i] == q_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                q_d[i]   = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        changed_d = |(q_d ^ q_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            q_q       <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            q_q       <= q_d;
            changed_q <= changed_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign io.a       = q_q[2];
    assign io.b       = q_q[1];
    assign io.c       = q_q[0];
    assign io.settled = (s2_q == q_q);
    assign io.changed = changed_q;
endmodule

// File: tb/tb_debounce3.sv
// Bench for debounce3 (STABLE_CYCLES=4): scripted scenarios with hand-derived checkpoints,
// then random raw inputs checked cycle by cycle against a sliding-window reference model.
module tb_debounce3;
    localparam int S = 4;

    logic clk;
    logic rst_n;
    debounce3_if io ();

    debounce3 #(.STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected outputs, packed as {a, b, c, settled, changed}.
    logic [4:0] exp_q[$];
    logic [4:0] got;

    // Reference model: synchronizer as a two-deep pipeline of raw samples; a channel
    // toggles when the last S synchronized samples since reset all disagree with it.
    logic [2:0] m_s1, m_s2, m_q;
    logic       m_changed;
    logic [2:0] hist[$];

    task automatic model_edge(input logic [2:0] raw, input logic rstn);
        logic [2:0] nq;
        bit         all_diff;
        if (!rstn) begin
            m_s1      = '0;
            m_s2      = '0;
            m_q       = '0;
            m_changed = 1'b0;
            hist.delete();
        end else begin
            nq = m_q;
            hist.push_back(m_s2);
            if (hist.size() > S) void'(hist.pop_front());
            for (int ch = 0; ch < 3; ch++) begin
                if (hist.size() == S) begin
                    all_diff = 1'b1;
                    foreach (hist[k]) if (hist[k][ch] == m_q[ch]) all_diff = 1'b0;
                    if (all_diff) nq[ch] = ~m_q[ch];
                end
            end
            m_changed = (nq != m_q);
            m_q       = nq;
            m_s2      = m_s1;
            m_s1      = raw;
        end
        exp_q.push_back({m_q, (m_s2 == m_q), m_changed});
    endtask

    task automatic cycle(input logic [2:0] raw, input logic rstn);
        logic [4:0] exp;
        @(negedge clk);
        io.a_raw = raw[2];
        io.b_raw = raw[1];
        io.c_raw = raw[0];
        rst_n    = rstn;
        @(posedge clk);
        model_edge(raw, rstn);
        #1;
        got = {io.a, io.b, io.c, io.settled, io.changed};
        exp = exp_q.pop_front();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL model t=%0t got=%b want=%b (a b c settled changed)", $time, got, exp);
        end
    endtask

    typedef struct {
        int         scen;
        int         edge_no;
        logic [4:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [2:0] scen_raw(input int s, input int e);
        case (s)
            1: return (e >= 10) ? 3'b100 : 3'b000;
            2: return (e >= 10 && e <= 12) ? 3'b010 : 3'b000;
            3: return (e >= 10 && e <= 13) ? 3'b001 : 3'b000;
            4: return (e >= 10) ? 3'b111 : 3'b000;
            5: begin
                if (e >= 30) return 3'b100;
                if (e >= 10 && ((e - 10) % 2 == 0)) return 3'b100;
                return 3'b000;
            end
            6: return (e >= 10) ? 3'b100 : 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    // Edge 0 is the last reset edge; edge 1 is the first edge after release.
    task automatic run_scen(input int s);
        logic rstn;
        cycle(3'b000, 1'b0);
        for (int e = 0; e <= 40; e++) begin
            rstn = !(e == 0 || (s == 6 && e == 13));
            cycle(scen_raw(s, e), rstn);
            foreach (tbl[i]) begin
                if (tbl[i].scen == s && tbl[i].edge_no == e) begin
                    total++;
                    if (got !== tbl[i].exp) begin
                        bad++;
                        $display("FAIL scen%0d_edge%0d got=%b want=%b (a b c settled changed)",
                                 s, e, got, tbl[i].exp);
                    end
                end
            end
        end
    endtask

    initial begin
        logic [2:0] r;
        logic       rr;

        rst_n    = 1'b0;
        io.a_raw = 1'b0;
        io.b_raw = 1'b0;
        io.c_raw = 1'b0;

        tbl.push_back('{1, 0,  5'b00010});
        tbl.push_back('{1, 10, 5'b00010});
        tbl.push_back('{1, 11, 5'b00000});
        tbl.push_back('{1, 14, 5'b00000});
        tbl.push_back('{1, 15, 5'b10011});
        tbl.push_back('{1, 16, 5'b10010});
        tbl.push_back('{2, 11, 5'b00000});
        tbl.push_back('{2, 13, 5'b00000});
        tbl.push_back('{2, 14, 5'b00010});
        tbl.push_back('{2, 15, 5'b00010});
        tbl.push_back('{2, 20, 5'b00010});
        tbl.push_back('{3, 15, 5'b00101});
        tbl.push_back('{3, 16, 5'b00100});
        tbl.push_back('{3, 18, 5'b00100});
        tbl.push_back('{3, 19, 5'b00011});
        tbl.push_back('{3, 20, 5'b00010});
        tbl.push_back('{4, 14, 5'b00000});
        tbl.push_back('{4, 15, 5'b11111});
        tbl.push_back('{4, 16, 5'b11110});
        tbl.push_back('{5, 34, 5'b00000});
        tbl.push_back('{5, 35, 5'b10011});
        tbl.push_back('{6, 12, 5'b00000});
        tbl.push_back('{6, 13, 5'b00010});
        tbl.push_back('{6, 15, 5'b00000});
        tbl.push_back('{6, 18, 5'b00000});
        tbl.push_back('{6, 19, 5'b10011});
        tbl.push_back('{6, 20, 5'b10010});

        for (int s = 1; s <= 6; s++) run_scen(s);

        // Random phase: slow-ish toggling so both glitches and real steps occur.
        r = 3'b000;
        cycle(r, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            for (int ch = 0; ch < 3; ch++) begin
                if ($urandom_range(0, 5) == 0) r[ch] = ~r[ch];
            end
            rr = ($urandom_range(0, 249) != 0);
            cycle(r, rr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
